// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the mult/div scheduler: op encodings, default latencies
// and FSM state encoding.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        return $clog2((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage side of the mult/div unit: operation request, operands, HI/LO and stall.
interface muldiv_ctrl_if;
    logic        StartE;
    logic [1:0]  MDOpE;
    logic        MTHIE;
    logic        MTLOE;
    logic [31:0] RSE;
    logic [31:0] RTE;
    logic        MDUseD;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        StallMD;

    modport master (
        output StartE, MDOpE, MTHIE, MTLOE, RSE, RTE, MDUseD,
        input  Busy, HI, LO, StallMD
    );

    modport slave (
        input  StartE, MDOpE, MTHIE, MTLOE, RSE, RTE, MDUseD,
        output Busy, HI, LO, StallMD
    );
endinterface

// File: rtl/muldiv_ctrl_core.sv
// Combinational 64-bit product and quotient/remainder; HI carries the high product
// word or the remainder, LO the low product word or the quotient.
module muldiv_core
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);
    logic        b_zero;
    logic [31:0] b_safe;
    logic        s_ovf;

    assign b_zero = (b == 32'd0);
    // Keep the divider away from /0 and INT_MIN/-1; the results are overridden anyway.
    assign b_safe = b_zero ? 32'd1 : b;
    assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        hi       = '0;
        lo       = '0;
        div_zero = 1'b0;
        unique case (op)
            MD_MULT:  {hi, lo} = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            MD_MULTU: {hi, lo} = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                div_zero = b_zero;
                if (s_ovf) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = $signed(a) / $signed(b_safe);
                    hi = $signed(a) % $signed(b_safe);
                end
            end
            MD_DIVU: begin
                div_zero = b_zero;
                lo       = a / b_safe;
                hi       = a % b_safe;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Mult/div scheduler: latches the result at start, holds Busy for a fixed latency,
// then commits to HI/LO. Also services mthi/mtlo and raises the EX stall.
//   state   | meaning
//   ST_IDLE | accepts start or mthi/mtlo
//   ST_RUN  | counting down, result waiting in pend_hi/pend_lo
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    muldiv_ctrl_if.slave md
);
    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;
    logic [31:0] res_hi, res_lo;
    logic        div_zero;

    muldiv_core u_core (
        .op       (md_op_e'(md.MDOpE)),
        .a        (md.RSE),
        .b        (md.RTE),
        .hi       (res_hi),
        .lo       (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        hi_n      = hi_q;
        lo_n      = lo_q;
        unique case (state)
            ST_IDLE: begin
                if (md.StartE) begin
                    state_n = ST_RUN;
                    cnt_n   = md.MDOpE[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    // A zero divisor commits the current HI/LO back, leaving them unchanged.
                    pend_hi_n = div_zero ? hi_q : res_hi;
                    pend_lo_n = div_zero ? lo_q : res_lo;
                end else begin
                    if (md.MTHIE) hi_n = md.RSE;
                    if (md.MTLOE) lo_n = md.RSE;
                end
            end
            ST_RUN: begin
                if (cnt == CW'(1)) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign md.Busy    = (state == ST_RUN);
    assign md.HI      = hi_q;
    assign md.LO      = lo_q;
    assign md.StallMD = md.MDUseD & (md.Busy | md.StartE);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl with a longint reference model.
module tb_muldiv_ctrl;
    import md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [31:0] m_hi, m_lo;

    muldiv_ctrl_if md();

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .md    (md)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi0, input logic [31:0] lo0,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sbv, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        hi  = hi0;
        lo  = lo0;
        case (op)
            2'd0: begin sp = sa * sbv; hi = sp[63:32]; lo = sp[31:0]; end
            2'd1: begin up = ua * ub;  hi = up[63:32]; lo = up[31:0]; end
            2'd2: if (b != 0) begin
                sq = sa / sbv; sr = sa % sbv; lo = sq[31:0]; hi = sr[31:0];
            end
            default: if (b != 0) begin
                up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0];
            end
        endcase
    endfunction

    // junk[0]: move alongside start (dropped); junk[1]: start/moves pulsed mid-run (ignored)
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic [1:0] junk);
        exp_t e;
        model(op, a, b, m_hi, m_lo, e.hi, e.lo);
        e.cycles = op[1] ? 10 : 5;
        md.StartE = 1'b1; md.MDOpE = op; md.RSE = a; md.RTE = b; md.MDUseD = use_d;
        md.MTHIE = junk[0]; md.MTLOE = junk[0];
        sb.push_back(e);
        #1 chk("stall_start", {31'd0, md.StallMD}, {31'd0, use_d});
        @(posedge Clk); #1;
        m_hi = e.hi; m_lo = e.lo;
        for (int i = 1; i <= e.cycles; i++) begin
            md.StartE = (junk[1] && i == 2);
            md.MTHIE  = (junk[1] && i == 2);
            md.MTLOE  = (junk[1] && i == 3);
            md.RSE    = (junk[1] && i >= 2) ? 32'hAAAA_5555 : $urandom;
            md.RTE    = $urandom;
            md.MDOpE  = 2'($urandom_range(0, 3));
            #1 chk("stall_busy", {31'd0, md.StallMD}, {31'd0, use_d});
            @(posedge Clk); #1;
        end
        chk("stall_after", {31'd0, md.StallMD}, 32'd0);
        md.MDUseD = 1'b0;
    endtask

    task automatic do_move(input logic to_hi, input logic [31:0] v);
        md.MTHIE = to_hi; md.MTLOE = ~to_hi; md.RSE = v;
        @(posedge Clk); #1;
        md.MTHIE = 1'b0; md.MTLOE = 1'b0;
        if (to_hi) m_hi = v; else m_lo = v;
        chk("move_hi", md.HI, m_hi);
        chk("move_lo", md.LO, m_lo);
        chk("move_busy", {31'd0, md.Busy}, 32'd0);
    endtask

    // Monitor: on every Busy fall, pop the oldest expected commit and compare.
    initial begin
        int   bcnt;
        bit   prev;
        exp_t e;
        bcnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                bcnt = 0; prev = 1'b0;
            end else if (md.Busy) begin
                bcnt++; prev = 1'b1;
                if (bcnt > 40) begin
                    checks++; failures++;
                    $display("FAIL busy_timeout actual=%0d cycles required<=10", bcnt);
                    bcnt = 0;
                end
            end else if (prev) begin
                prev = 1'b0;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_commit actual=commit required=none");
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", bcnt, e.cycles);
                    chk("commit_hi", md.HI, e.hi);
                    chk("commit_lo", md.LO, e.lo);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        m_hi = 0; m_lo = 0;
        md.StartE = 0; md.MDOpE = 0; md.MTHIE = 0; md.MTLOE = 0;
        md.RSE = 0; md.RTE = 0; md.MDUseD = 1;
        #12;
        chk("rst_busy", {31'd0, md.Busy}, 32'd0);
        chk("rst_hi", md.HI, 32'd0);
        chk("rst_lo", md.LO, 32'd0);
        chk("rst_stall", {31'd0, md.StallMD}, 32'd0);
        md.MDUseD = 0;
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1;

        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 2'b00);
        chk("mult_hi", md.HI, 32'hFFFF_FFFF);
        chk("mult_lo", md.LO, 32'hFFFF_FFF1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'b00);
        chk("multu_hi", md.HI, 32'h0000_0001);
        chk("multu_lo", md.LO, 32'hFFFF_FFFE);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b00);
        chk("div_lo", md.LO, 32'hFFFF_FFFD);
        chk("div_hi", md.HI, 32'hFFFF_FFFF);
        do_move(1'b1, 32'h11);
        do_move(1'b0, 32'h22);
        do_op(2'd3, 32'h1234_5678, 32'd0, 1'b0, 2'b00);
        chk("divz_hi", md.HI, 32'h11);
        chk("divz_lo", md.LO, 32'h22);
        do_op(2'd0, 32'd7, 32'd9, 1'b1, 2'b10);
        chk("junk_hi", md.HI, 32'd0);
        chk("junk_lo", md.LO, 32'd63);
        do_op(2'd1, 32'd3, 32'd4, 1'b0, 2'b01);
        chk("drop_move_hi", md.HI, 32'd0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00);

        // Reset in busy cycle 4 of a divide
        md.StartE = 1'b1; md.MDOpE = 2'd2; md.RSE = 32'd100; md.RTE = 32'd7;
        @(posedge Clk); #1;
        md.StartE = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        chk("pre_rst_busy", {31'd0, md.Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, md.Busy}, 32'd0);
        chk("arst_hi", md.HI, 32'd0);
        chk("arst_lo", md.LO, 32'd0);
        m_hi = 0; m_lo = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (12) begin @(posedge Clk); #1; end
        chk("no_commit_busy", {31'd0, md.Busy}, 32'd0);
        chk("no_commit_hi", md.HI, 32'd0);
        chk("no_commit_lo", md.LO, 32'd0);
        do_op(2'd0, 32'd6, 32'hFFFF_FFFE, 1'b1, 2'b00);
        chk("post_rst_lo", md.LO, 32'hFFFF_FFF4);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) do_move($urandom_range(0, 1) == 1, $urandom);
            do_op(op, a, b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        @(posedge Clk); #1;
        chk("sb_empty", sb.size(), 32'd0);
        chk("final_hi", md.HI, m_hi);
        chk("final_lo", md.LO, m_lo);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
